// File: rtl/latch_monitor_if.sv
// Signal bundle between a D-latch under observation and its checking monitor.
// The master side drives the latch observations; the slave side is the monitor.
interface latch_monitor_if #(
  parameter int CW = 8
);
  logic          en;
  logic          d_obs;
  logic          g_obs;
  logic          q_obs;
  logic          qn_obs;
  logic          busy;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic          err_sticky;
  logic          halted;
  logic [CW-1:0] chk_cnt;
  logic [CW-1:0] err_cnt;

  modport master (
    output en, d_obs, g_obs, q_obs, qn_obs,
    input  busy, err_pulse, err_code, err_sticky, halted, chk_cnt, err_cnt
  );

  modport slave (
    input  en, d_obs, g_obs, q_obs, qn_obs,
    output busy, err_pulse, err_code, err_sticky, halted, chk_cnt, err_cnt
  );
endinterface

// File: rtl/latch_monitor.sv
// Clocked observer for a transparent D-latch: runs a reference latch model,
// delays it by LAT samples and checks q/qn against it, with status and counters.
//
// state | meaning
// IDLE  | monitoring off, counters and sticky held
// FILL  | model and delay line priming, no comparisons
// RUN   | model running, complement and value checks active
// HALT  | frozen after first error (STOP_ON_ERR only)
module latch_monitor #(
  parameter int LAT         = 1,
  parameter int CW          = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rest,
  latch_monitor_if.slave   mon
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [2:0] FILL_LOAD = 3'(LAT - 1);

  state_t        state;
  state_t        state_nxt;

  logic [2:0]    fill_cnt;
  logic          exp;
  logic          exp_vld;
  logic [LAT-1:0] dl_exp;
  logic [LAT-1:0] dl_vld;

  logic          err_pulse;
  logic [1:0]    err_code;
  logic          err_sticky;
  logic [CW-1:0] chk_cnt;
  logic [CW-1:0] err_cnt;

  logic          fill_done;
  logic          cmp_en;
  logic          cpl_err;
  logic          val_err;
  logic          exp_nxt;
  logic          vld_nxt;
  logic          model_en;
  logic          do_check;
  logic          do_enter;

  always_comb begin
    fill_done = (fill_cnt == 3'd0);
    cmp_en    = dl_vld[LAT-1];
    cpl_err   = (mon.q_obs == mon.qn_obs);
    val_err   = cmp_en && (mon.q_obs != dl_exp[LAT-1]);
    exp_nxt   = mon.g_obs ? mon.d_obs : exp;
    vld_nxt   = mon.g_obs | exp_vld;

    state_nxt = state;
    model_en  = 1'b0;
    do_check  = 1'b0;
    do_enter  = 1'b0;

    // en low wins over every other transition out of an active state
    case (state)
      ST_IDLE: begin
        if (mon.en) begin
          state_nxt = ST_FILL;
          do_enter  = 1'b1;
        end
      end
      ST_FILL: begin
        if (!mon.en) begin
          state_nxt = ST_IDLE;
        end else begin
          model_en = 1'b1;
          if (fill_done) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!mon.en) begin
          state_nxt = ST_IDLE;
        end else begin
          model_en = 1'b1;
          do_check = 1'b1;
          if ((STOP_ON_ERR != 0) && (cpl_err || val_err)) state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!mon.en) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      fill_cnt   <= 3'd0;
      exp        <= 1'b0;
      exp_vld    <= 1'b0;
      dl_exp     <= '0;
      dl_vld     <= '0;
      err_pulse  <= 1'b0;
      err_code   <= 2'b00;
      err_sticky <= 1'b0;
      chk_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      err_pulse <= 1'b0;
      err_code  <= 2'b00;

      if (do_enter) begin
        exp_vld  <= 1'b0;
        dl_exp   <= '0;
        dl_vld   <= '0;
        fill_cnt <= FILL_LOAD;
      end

      // stage 0 takes the model value of this edge so stage LAT-1 lines up
      // with q/qn sampled LAT edges later
      if (model_en) begin
        exp     <= exp_nxt;
        exp_vld <= vld_nxt;
        for (int i = LAT - 1; i > 0; i--) begin
          dl_exp[i] <= dl_exp[i-1];
          dl_vld[i] <= dl_vld[i-1];
        end
        dl_exp[0] <= exp_nxt;
        dl_vld[0] <= vld_nxt;
        if (!fill_done) fill_cnt <= fill_cnt - 3'd1;
      end

      if (do_check) begin
        if (cmp_en && (chk_cnt != '1)) chk_cnt <= chk_cnt + CW'(1);
        if (cpl_err || val_err) begin
          err_pulse  <= 1'b1;
          err_code   <= {cpl_err, val_err};
          err_sticky <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
        end
      end
    end
  end

  assign mon.busy       = (state == ST_FILL) || (state == ST_RUN);
  assign mon.halted     = (state == ST_HALT);
  assign mon.err_pulse  = err_pulse;
  assign mon.err_code   = err_code;
  assign mon.err_sticky = err_sticky;
  assign mon.chk_cnt    = chk_cnt;
  assign mon.err_cnt    = err_cnt;

endmodule

// File: tb/tb_latch_monitor.sv
// Directed bench for latch_monitor: three instances cover LAT=1 free-running,
// LAT=3 stop-on-error, and CW=4 counter saturation.
module tb_latch_monitor;

  logic clk;
  logic rest;
  int   n_total;
  int   n_pass;

  latch_monitor_if #(.CW(8)) ia ();
  latch_monitor_if #(.CW(8)) ib ();
  latch_monitor_if #(.CW(4)) ic ();

  latch_monitor #(.LAT(1), .CW(8), .STOP_ON_ERR(0)) u_a (.clk(clk), .rest(rest), .mon(ia));
  latch_monitor #(.LAT(3), .CW(8), .STOP_ON_ERR(1)) u_b (.clk(clk), .rest(rest), .mon(ib));
  latch_monitor #(.LAT(2), .CW(4), .STOP_ON_ERR(0)) u_c (.clk(clk), .rest(rest), .mon(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic e, input logic d, input logic g, input logic q, input logic qn);
    ia.en = e; ia.d_obs = d; ia.g_obs = g; ia.q_obs = q; ia.qn_obs = qn;
  endtask

  task automatic drv_b(input logic e, input logic d, input logic g, input logic q, input logic qn);
    ib.en = e; ib.d_obs = d; ib.g_obs = g; ib.q_obs = q; ib.qn_obs = qn;
  endtask

  task automatic drv_c(input logic e, input logic d, input logic g, input logic q, input logic qn);
    ic.en = e; ic.d_obs = d; ic.g_obs = g; ic.q_obs = q; ic.qn_obs = qn;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rest    = 1'b1;
    drv_a(0, 0, 0, 0, 1);
    drv_b(0, 0, 0, 0, 1);
    drv_c(0, 0, 0, 0, 1);

    // reset and idle
    step(); step();
    rest = 1'b0;
    repeat (5) step();
    check("rst_busy",    32'(ia.busy), 32'd0);
    check("rst_pulse",   32'(ia.err_pulse), 32'd0);
    check("rst_code",    32'(ia.err_code), 32'd0);
    check("rst_sticky",  32'(ia.err_sticky), 32'd0);
    check("rst_halted",  32'(ia.halted), 32'd0);
    check("rst_chk",     32'(ia.chk_cnt), 32'd0);
    check("rst_err",     32'(ia.err_cnt), 32'd0);
    check("rst_b_chk",   32'(ib.chk_cnt), 32'd0);
    check("rst_c_err",   32'(ic.err_cnt), 32'd0);

    // LAT=1 correct latch
    drv_a(1, 0, 0, 0, 1); step();
    check("a_busy_fill", 32'(ia.busy), 32'd1);
    drv_a(1, 1, 1, 0, 1); step();
    drv_a(1, 0, 1, 1, 0); step();
    drv_a(1, 1, 1, 0, 1); step();
    drv_a(1, 0, 0, 1, 0); step();
    drv_a(1, 1, 0, 1, 0); step();
    drv_a(1, 0, 0, 1, 0); step();
    check("a_good_chk",    32'(ia.chk_cnt), 32'd5);
    check("a_good_err",    32'(ia.err_cnt), 32'd0);
    check("a_good_sticky", 32'(ia.err_sticky), 32'd0);
    check("a_good_pulse",  32'(ia.err_pulse), 32'd0);

    // hold violation: gate closed with exp=1, q drops
    drv_a(1, 0, 0, 0, 1); step();
    check("a_hold_pulse",  32'(ia.err_pulse), 32'd1);
    check("a_hold_code",   32'(ia.err_code), 32'd1);
    check("a_hold_err",    32'(ia.err_cnt), 32'd1);
    check("a_hold_sticky", 32'(ia.err_sticky), 32'd1);
    check("a_hold_chk",    32'(ia.chk_cnt), 32'd6);
    drv_a(1, 0, 0, 1, 0); step();
    check("a_after_pulse", 32'(ia.err_pulse), 32'd0);
    check("a_after_code",  32'(ia.err_code), 32'd0);
    check("a_after_chk",   32'(ia.chk_cnt), 32'd7);

    // en low: faulty sample at that edge is ignored
    drv_a(0, 0, 0, 1, 1); step();
    check("a_off_busy",  32'(ia.busy), 32'd0);
    check("a_off_pulse", 32'(ia.err_pulse), 32'd0);
    check("a_off_err",   32'(ia.err_cnt), 32'd1);

    // complement fault before any transparent phase
    drv_a(1, 0, 0, 0, 1); step();
    drv_a(1, 0, 0, 0, 1); step();
    drv_a(1, 0, 0, 1, 1); step();
    check("a_cpl_code",  32'(ia.err_code), 32'd2);
    check("a_cpl_chk",   32'(ia.chk_cnt), 32'd7);
    check("a_cpl_err",   32'(ia.err_cnt), 32'd2);
    drv_a(1, 0, 1, 0, 1); step();
    check("a_cpl_clear", 32'(ia.err_pulse), 32'd0);
    drv_a(1, 0, 0, 1, 1); step();
    check("a_both_code", 32'(ia.err_code), 32'd3);
    check("a_both_err",  32'(ia.err_cnt), 32'd3);
    check("a_both_chk",  32'(ia.chk_cnt), 32'd8);
    drv_a(0, 0, 0, 0, 1); step();

    // LAT=3 stop on error
    drv_b(1, 0, 0, 0, 1); step();
    drv_b(1, 1, 1, 0, 1); step();
    drv_b(1, 0, 0, 0, 1); step();
    drv_b(1, 0, 0, 0, 1); step();
    check("b_fill_chk",  32'(ib.chk_cnt), 32'd0);
    check("b_run_busy",  32'(ib.busy), 32'd1);
    drv_b(1, 0, 0, 1, 0); step();
    check("b_first_chk", 32'(ib.chk_cnt), 32'd1);
    check("b_first_pulse", 32'(ib.err_pulse), 32'd0);
    drv_b(1, 0, 0, 0, 1); step();
    check("b_halt",      32'(ib.halted), 32'd1);
    check("b_halt_pulse", 32'(ib.err_pulse), 32'd1);
    check("b_halt_code", 32'(ib.err_code), 32'd1);
    check("b_halt_busy", 32'(ib.busy), 32'd0);
    drv_b(1, 0, 0, 1, 1); step();
    check("b_halt_drop", 32'(ib.err_pulse), 32'd0);
    repeat (9) step();
    check("b_frz_chk",   32'(ib.chk_cnt), 32'd2);
    check("b_frz_err",   32'(ib.err_cnt), 32'd1);
    check("b_frz_halt",  32'(ib.halted), 32'd1);
    drv_b(0, 0, 0, 1, 1); step();
    check("b_idle_halt", 32'(ib.halted), 32'd0);
    check("b_idle_chk",  32'(ib.chk_cnt), 32'd2);
    check("b_idle_err",  32'(ib.err_cnt), 32'd1);
    check("b_idle_sticky", 32'(ib.err_sticky), 32'd1);

    // CW=4 saturation, both error kinds every cycle
    drv_c(1, 0, 0, 0, 1); step();
    drv_c(1, 0, 1, 0, 1); step();
    drv_c(1, 0, 0, 0, 1); step();
    check("c_fill_chk", 32'(ic.chk_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drv_c(1, 0, 0, 1, 1); step();
      if (i == 14) check("c_err_15", 32'(ic.err_cnt), 32'd15);
    end
    check("c_sat_err",   32'(ic.err_cnt), 32'd15);
    check("c_sat_chk",   32'(ic.chk_cnt), 32'd15);
    check("c_sat_code",  32'(ic.err_code), 32'd3);

    // reset mid-RUN with a faulty sample at the reset edge
    rest = 1'b1; step();
    check("c_rst_pulse",  32'(ic.err_pulse), 32'd0);
    check("c_rst_busy",   32'(ic.busy), 32'd0);
    check("c_rst_err",    32'(ic.err_cnt), 32'd0);
    check("c_rst_chk",    32'(ic.chk_cnt), 32'd0);
    check("c_rst_sticky", 32'(ic.err_sticky), 32'd0);
    check("b_rst_chk",    32'(ib.chk_cnt), 32'd0);
    check("a_rst_sticky", 32'(ia.err_sticky), 32'd0);
    rest = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
